// File: rtl/card_shoe_if.sv
// Card shoe handshake bundle: shuffle control, dealt-card payload and shoe status.
// The seed_in signal exists only when SHOE_SEED_EN is defined.
interface card_shoe_if #(
    parameter int CNT_W  = 6,
    parameter int LFSR_W = 16
);
    logic             shuffle_start;
    logic             busy;
    logic             card_valid;
    logic             card_ready;
    logic [6:0]       card_code;
    logic [3:0]       card_value;
    logic [CNT_W-1:0] cards_left;
    logic             reshuffle_due;
`ifdef SHOE_SEED_EN
    logic [LFSR_W-1:0] seed_in;

    modport master (
        input  shuffle_start, card_ready, seed_in,
        output busy, card_valid, card_code, card_value, cards_left, reshuffle_due
    );
    modport slave (
        output shuffle_start, card_ready, seed_in,
        input  busy, card_valid, card_code, card_value, cards_left, reshuffle_due
    );
`else
    modport master (
        input  shuffle_start, card_ready,
        output busy, card_valid, card_code, card_value, cards_left, reshuffle_due
    );
    modport slave (
        output shuffle_start, card_ready,
        input  busy, card_valid, card_code, card_value, cards_left, reshuffle_due
    );
`endif
endinterface

// File: rtl/card_shoe.sv
// Multi-deck card shoe: in-order fill, LFSR-driven Fisher-Yates shuffle, valid/ready dealing.
// Optional macro SHOE_SEED_EN adds seed_in, reloading the LFSR on every shuffle_start.
module card_shoe #(
    parameter int                NUM_DECKS = 1,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
    parameter int                CUT_LEFT  = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    card_shoe_if.master shoe
);
    localparam int TOTAL = 52 * NUM_DECKS;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int PW    = LFSR_W + CNT_W;
    // Taps x^16+x^14+x^13+x^11+1, aligned to the top of wider registers
    localparam logic [LFSR_W-1:0] LFSR_MASK = LFSR_W'(16'hB400) << (LFSR_W - 16);

    typedef enum logic [1:0] {S_EMPTY, S_INIT, S_SHUFFLE, S_READY} state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  idx_reg;
    logic [CNT_W-1:0]  head_reg;
    logic [CNT_W-1:0]  left_reg;
    logic [5:0]        dcnt_reg;
    logic [LFSR_W-1:0] lfsr_reg;
    logic [5:0]        entry_reg [TOTAL];

    logic [CNT_W-1:0]  i_plus1;
    logic [PW-1:0]     prod;
    logic [CNT_W-1:0]  j_idx;
    logic [5:0]        ent_i;
    logic [5:0]        ent_j;
    logic [LFSR_W-1:0] lfsr_next;
    logic              valid_w;
    logic              do_init;
    logic              do_swap;

    always_comb begin
        i_plus1   = idx_reg + CNT_W'(1);
        prod      = {{CNT_W{1'b0}}, lfsr_reg} * {{LFSR_W{1'b0}}, i_plus1};
        j_idx     = prod[PW-1:LFSR_W];
        ent_i     = entry_reg[idx_reg];
        ent_j     = entry_reg[j_idx];
        lfsr_next = {1'b0, lfsr_reg[LFSR_W-1:1]} ^ (lfsr_reg[0] ? LFSR_MASK : '0);
        valid_w   = (state_reg == S_READY) && (left_reg != '0);
        do_init   = (state_reg == S_INIT) && !shoe.shuffle_start;
        do_swap   = (state_reg == S_SHUFFLE) && !shoe.shuffle_start;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_EMPTY;
            lfsr_reg  <= SEED;
            idx_reg   <= '0;
            head_reg  <= '0;
            left_reg  <= '0;
            dcnt_reg  <= '0;
        end else if (shoe.shuffle_start) begin
            // Restart wins over everything, including a same-cycle handshake
            state_reg <= S_INIT;
            idx_reg   <= '0;
            dcnt_reg  <= '0;
            head_reg  <= '0;
            left_reg  <= '0;
`ifdef SHOE_SEED_EN
            lfsr_reg  <= (shoe.seed_in == '0) ? SEED : shoe.seed_in;
`endif
        end else begin
            case (state_reg)
                S_INIT: begin
                    dcnt_reg <= (dcnt_reg == 6'd51) ? 6'd0 : dcnt_reg + 6'd1;
                    if (idx_reg == CNT_W'(TOTAL - 1)) begin
                        state_reg <= S_SHUFFLE;
                    end else begin
                        idx_reg <= idx_reg + CNT_W'(1);
                    end
                end
                S_SHUFFLE: begin
                    lfsr_reg <= lfsr_next;
                    if (idx_reg == CNT_W'(1)) begin
                        state_reg <= S_READY;
                        head_reg  <= '0;
                        left_reg  <= CNT_W'(TOTAL);
                    end else begin
                        idx_reg <= idx_reg - CNT_W'(1);
                    end
                end
                S_READY: begin
                    if (valid_w && shoe.card_ready) begin
                        head_reg <= head_reg + CNT_W'(1);
                        left_reg <= left_reg - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Contents are don't-care after reset, so the storage carries no reset
    for (genvar gi = 0; gi < TOTAL; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (do_init && idx_reg == CNT_W'(gi)) begin
                entry_reg[gi] <= dcnt_reg;
            end else if (do_swap) begin
                if (idx_reg == CNT_W'(gi)) begin
                    entry_reg[gi] <= ent_j;
                end else if (j_idx == CNT_W'(gi)) begin
                    entry_reg[gi] <= ent_i;
                end
            end
        end
    end

    logic [5:0] head_d;
    logic [1:0] suit;
    logic [5:0] suit_base;
    logic [3:0] rank;

    always_comb begin
        head_d    = valid_w ? entry_reg[head_reg] : 6'd0;
        suit      = 2'd0;
        suit_base = 6'd0;
        if (head_d >= 6'd39) begin
            suit = 2'd3; suit_base = 6'd39;
        end else if (head_d >= 6'd26) begin
            suit = 2'd2; suit_base = 6'd26;
        end else if (head_d >= 6'd13) begin
            suit = 2'd1; suit_base = 6'd13;
        end
        rank = 4'(head_d - suit_base + 6'd1);

        shoe.busy          = (state_reg == S_INIT) || (state_reg == S_SHUFFLE);
        shoe.card_valid    = valid_w;
        shoe.cards_left    = left_reg;
        shoe.reshuffle_due = valid_w && (left_reg < CNT_W'(CUT_LEFT));
        shoe.card_code     = '0;
        shoe.card_value    = '0;
        if (valid_w) begin
            shoe.card_code  = {1'b0, suit, rank};
            shoe.card_value = (rank > 4'd10) ? 4'd10 : rank;
        end
    end
endmodule

// File: tb/tb_card_shoe.sv
// Self-checking bench for card_shoe: control table, reset cases, randomized deals vs a reference model.
module tb_card_shoe;
    localparam int          ND     = 1;
    localparam int          TOTAL  = 52 * ND;
    localparam int          CNT_W  = $clog2(TOTAL + 1);
    localparam int          CUT    = 15;
    localparam logic [15:0] SEED_V = 16'hACE1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    card_shoe_if #(.CNT_W(CNT_W), .LFSR_W(16)) bus ();

    card_shoe #(.NUM_DECKS(ND), .LFSR_W(16), .SEED(SEED_V), .CUT_LEFT(CUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .shoe  (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    int unsigned m_lfsr = SEED_V;
    int          m_deck [TOTAL];
    int          m_head = 0;
    int          m_left = 0;
    bit          m_rdy  = 0;

    function automatic int code_of(input int d);
        return (d / 13) * 16 + (d % 13) + 1;
    endfunction

    function automatic int value_of(input int d);
        int r;
        r = (d % 13) + 1;
        return (r > 10) ? 10 : r;
    endfunction

    task automatic m_start(input int s);
        m_rdy  = 0;
        m_left = 0;
        m_head = 0;
`ifdef SHOE_SEED_EN
        m_lfsr = (s == 0) ? SEED_V : s;
`else
        if (s < 0) m_lfsr = SEED_V;
`endif
    endtask

    task automatic m_shuffle();
        int j, t;
        for (int k = 0; k < TOTAL; k++) m_deck[k] = k % 52;
        for (int i = TOTAL - 1; i >= 1; i--) begin
            j = int'((longint'(m_lfsr) * longint'(i + 1)) >> 16);
            t = m_deck[i]; m_deck[i] = m_deck[j]; m_deck[j] = t;
            m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? 32'hB400 : 32'h0);
        end
        m_head = 0;
        m_left = TOTAL;
        m_rdy  = 1;
    endtask

    task automatic check_outputs(input string tag);
        bit mv;
        mv = m_rdy && (m_left != 0);
        check({tag, "_valid"}, 32'(bus.card_valid), 32'(mv));
        check({tag, "_left"},  32'(bus.cards_left), 32'(m_left));
        check({tag, "_due"},   32'(bus.reshuffle_due), 32'(mv && (m_left < CUT)));
        check({tag, "_code"},  32'(bus.card_code),  mv ? 32'(code_of(m_deck[m_head])) : 32'd0);
        check({tag, "_value"}, 32'(bus.card_value), mv ? 32'(value_of(m_deck[m_head])) : 32'd0);
    endtask

    // Pulse shuffle_start and check the exact busy / card_valid timeline.
    task automatic do_shuffle(input string tag, input int seed);
        bus.shuffle_start = 1'b1;
`ifdef SHOE_SEED_EN
        bus.seed_in = 16'(seed);
`endif
        tick();
        bus.shuffle_start = 1'b0;
        m_start(seed);
        for (int c = 0; c < 2 * TOTAL; c++) begin
            if (c > 0) tick();
            check({tag, "_timeline"}, {30'd0, bus.busy, bus.card_valid},
                  {30'd0, (c < 2 * TOTAL - 1) ? 1'b1 : 1'b0, (c == 2 * TOTAL - 1) ? 1'b1 : 1'b0});
        end
        m_shuffle();
        check_outputs({tag, "_ready"});
    endtask

    int rec_q [$];

    // Deal the whole shoe with random or constant card_ready, checking every cycle.
    task automatic deal_all(input string tag, input bit rnd);
        int  guard;
        bit  rdy, mv;
        int  hist [128];
        rec_q.delete();
        guard = 0;
        while (m_left > 0 && guard < 20 * TOTAL) begin
            check_outputs(tag);
            rdy = rnd ? ($urandom_range(0, 99) < 65) : 1'b1;
            mv  = m_rdy && (m_left != 0);
            if (rdy && mv) rec_q.push_back(int'(bus.card_code));
            bus.card_ready = rdy;
            tick();
            if (rdy && mv) begin
                m_head++;
                m_left--;
            end
            guard++;
        end
        bus.card_ready = 1'b0;
        check({tag, "_finished"}, 32'(m_left), 32'd0);
        check_outputs({tag, "_empty"});
        for (int k = 0; k < 128; k++) hist[k] = 0;
        foreach (rec_q[k]) hist[rec_q[k] & 127]++;
        for (int s = 0; s < 4; s++)
            for (int r = 1; r <= 13; r++)
                check({tag, "_hist"}, 32'(hist[s * 16 + r]), 32'(ND));
    endtask

    // ---------------- control table ----------------
    typedef struct {
        bit start;
        bit ready;
        int waitc;
        bit e_busy;
        bit e_valid;
        int e_left;
        bit e_due;
    } vec_t;

    vec_t tbl [11];
    int   q1 [$];
    int   q2 [$];

    initial begin
        tbl[0]  = '{0, 1, 0,             0, 0, 0,          0};
        tbl[1]  = '{1, 0, 0,             1, 0, 0,          0};
        tbl[2]  = '{0, 0, 2 * TOTAL - 3, 1, 0, 0,          0};
        tbl[3]  = '{0, 0, 0,             0, 1, TOTAL,      0};
        tbl[4]  = '{0, 1, 9,             0, 1, TOTAL - 10, 0};
        tbl[5]  = '{1, 1, 0,             1, 0, 0,          0};
        tbl[6]  = '{0, 1, 2 * TOTAL - 2, 0, 1, TOTAL,      0};
        tbl[7]  = '{0, 1, TOTAL - CUT - 1, 0, 1, CUT,      0};
        tbl[8]  = '{0, 1, 0,             0, 1, CUT - 1,    1};
        tbl[9]  = '{0, 1, CUT - 2,       0, 0, 0,          0};
        tbl[10] = '{0, 1, 4,             0, 0, 0,          0};

        bus.shuffle_start = 1'b0;
        bus.card_ready    = 1'b0;
`ifdef SHOE_SEED_EN
        bus.seed_in = 16'h0;
`endif
        // Reset state with all inputs low
        #2;
        check_outputs("reset");
        check("reset_busy", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        begin
            int vcnt, bcnt;
            vcnt = 0; bcnt = 0;
            bus.card_ready = 1'b1;
            repeat (200) begin
                tick();
                vcnt += int'(bus.card_valid);
                bcnt += int'(bus.busy);
            end
            bus.card_ready = 1'b0;
            check("idle_valid_count", 32'(vcnt), 32'd0);
            check("idle_busy_count",  32'(bcnt), 32'd0);
        end

        // Table-driven control sequence: fill/shuffle timing, restart over handshake, cut card
        for (int n = 0; n < 11; n++) begin
            bus.shuffle_start = tbl[n].start;
            bus.card_ready    = tbl[n].ready;
            tick();
            bus.shuffle_start = 1'b0;
            repeat (tbl[n].waitc) tick();
            check($sformatf("tbl%0d_busy", n),  32'(bus.busy),          32'(tbl[n].e_busy));
            check($sformatf("tbl%0d_valid", n), 32'(bus.card_valid),    32'(tbl[n].e_valid));
            check($sformatf("tbl%0d_left", n),  32'(bus.cards_left),    32'(tbl[n].e_left));
            check($sformatf("tbl%0d_due", n),   32'(bus.reshuffle_due), 32'(tbl[n].e_due));
        end
        bus.card_ready = 1'b0;
        // Two complete shuffles ran during the table
        m_start(0); m_shuffle();
        m_start(0); m_shuffle();
        m_left = 0;
        check_outputs("after_table");

        // Reset in the middle of SHUFFLE
        bus.shuffle_start = 1'b1;
        tick();
        bus.shuffle_start = 1'b0;
        repeat (70) tick();
        check("pre_reset_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        m_lfsr = SEED_V; m_rdy = 0; m_left = 0; m_head = 0;
        check("async_reset_busy", 32'(bus.busy), 32'd0);
        check_outputs("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        begin
            int vcnt;
            vcnt = 0;
            bus.card_ready = 1'b1;
            repeat (200) begin
                tick();
                vcnt += int'(bus.card_valid);
            end
            bus.card_ready = 1'b0;
            check("post_reset_valid_count", 32'(vcnt), 32'd0);
        end

        // Deterministic full deal, then randomized rounds (LFSR carries over)
        do_shuffle("shuf0", 0);
        deal_all("deal0", 1'b0);
        for (int r = 0; r < 4; r++) begin
            do_shuffle($sformatf("shuf_r%0d", r), int'($urandom_range(1, 65535)));
            deal_all($sformatf("deal_r%0d", r), 1'b1);
        end

`ifdef SHOE_SEED_EN
        do_shuffle("seedA1", 16'h1234);
        deal_all("dealA1", 1'b1);
        q1 = rec_q;
        do_shuffle("seedA2", 16'h1234);
        deal_all("dealA2", 1'b1);
        q2 = rec_q;
        check("seedA_len", 32'(q2.size()), 32'(q1.size()));
        for (int k = 0; k < TOTAL; k++) check($sformatf("seedA_card%0d", k), 32'(q2[k]), 32'(q1[k]));
        do_shuffle("seed0", 0);
        deal_all("deal0s", 1'b0);
        q1 = rec_q;
        do_shuffle("seedD", int'(SEED_V));
        deal_all("dealDs", 1'b0);
        q2 = rec_q;
        for (int k = 0; k < TOTAL; k++) check($sformatf("seed0_card%0d", k), 32'(q1[k]), 32'(q2[k]));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
